// File: rtl/switch_led_controller.sv
// switch_led_controller
//   Debounces four slide switches and a mode pushbutton, then drives four LEDs
//   in one of three modes: PASS (LEDs mirror switches), CHASE (single walking
//   bit), BLINK (all LEDs toggle). A pattern tick paces CHASE and BLINK.
//
//   Optional feature macro: SWITCH_LED_BLINK_MODE_EN
//     defined   -> modes cycle PASS -> CHASE -> BLINK -> PASS
//     undefined -> BLINK is not built; modes cycle PASS -> CHASE -> PASS
//
//   Ports
//     iClk      : clock, all state updates on the rising edge
//     iRst_n    : asynchronous active-low reset
//     iSwitch   : raw slide switches (asynchronous to iClk)
//     iBtn      : raw mode-advance pushbutton (asynchronous to iClk)
//     oLED      : registered LED drive
//     oMode     : current mode (0=PASS, 1=CHASE, 2=BLINK)

// Per-bit synchronizer + debouncer. The counter tracks how many consecutive
// cycles the synchronized input has disagreed with the debounced value; any
// agreement clears it, so only an uninterrupted run of DEBOUNCE_CYCLES flips
// the output.
module switch_led_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iRaw,
   output logic oDeb
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         oDeb  <= 1'b0;
      end else begin
         sync1 <= iRaw;
         sync2 <= sync1;
         if (sync2 == oDeb) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            oDeb <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module switch_led_controller #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TICK_CYCLES     = 25000000
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic [3:0] iSwitch,
   input  logic       iBtn,
   output logic [3:0] oLED,
   output logic [1:0] oMode
);
   localparam int TW = $clog2(TICK_CYCLES);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam int NUM_IN = 5;

`ifdef SWITCH_LED_BLINK_MODE_EN
   typedef enum logic [1:0] {PASS = 2'd0, CHASE = 2'd1, BLINK = 2'd2} modeT;
`else
   typedef enum logic [1:0] {PASS = 2'd0, CHASE = 2'd1} modeT;
`endif

   logic [NUM_IN-1:0] rawBits;
   logic [NUM_IN-1:0] debBits;
   logic [3:0]        debSw;
   logic              debBtn;
   logic              btnPrev;
   logic              press;
   logic [TW-1:0]     tickCnt;
   logic              tick;
   modeT              state;
   modeT              stateNext;
   logic [3:0]        ledNext;

   assign rawBits = {iBtn, iSwitch};

   for (genvar g = 0; g < NUM_IN; g++) begin : gDeb
      switch_led_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDeb (
         .iClk   (iClk),
         .iRst_n (iRst_n),
         .iRaw   (rawBits[g]),
         .oDeb   (debBits[g])
      );
   end

   assign debSw  = debBits[3:0];
   assign debBtn = debBits[4];

   // btnPrev resets to 0 alongside the debounced bit, so a button held through
   // reset yields no pulse until its debounced value actually rises.
   assign press = debBtn & ~btnPrev;
   assign tick  = (tickCnt == TICK_LAST);
   assign oMode = state;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state   <= PASS;
         oLED    <= 4'b0000;
         btnPrev <= 1'b0;
         tickCnt <= '0;
      end else begin
         state   <= stateNext;
         oLED    <= ledNext;
         btnPrev <= debBtn;
         // A mode change restarts the pattern period.
         tickCnt <= (press || tick) ? '0 : tickCnt + 1'b1;
      end
   end

   // A press outranks a coincident tick: the entry pattern is loaded and the
   // tick is dropped.
   always_comb begin
      stateNext = state;
      ledNext   = oLED;
      if (press) begin
         case (state)
            PASS: begin
               stateNext = CHASE;
               ledNext   = 4'b0001;
            end
`ifdef SWITCH_LED_BLINK_MODE_EN
            CHASE: begin
               stateNext = BLINK;
               ledNext   = 4'b1111;
            end
`endif
            default: begin
               stateNext = PASS;
               ledNext   = debSw;
            end
         endcase
      end else begin
         case (state)
            PASS:  ledNext = debSw;
            CHASE: if (tick) ledNext = {oLED[2:0], oLED[3]};
`ifdef SWITCH_LED_BLINK_MODE_EN
            BLINK: if (tick) ledNext = ~oLED;
`endif
            default: begin
               stateNext = PASS;
               ledNext   = debSw;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_switch_led_controller.sv
// tb_switch_led_controller
//   Directed + randomized stimulus for switch_led_controller with
//   DEBOUNCE_CYCLES=4, TICK_CYCLES=8. Expected LED/mode values come from a
//   behavioural model: debounce as "last D synchronized samples all disagree",
//   patterns as step counts since mode entry.
module tb_switch_led_controller;
   localparam int DEB  = 4;
   localparam int TICK = 8;

   logic       iClk;
   logic       iRst_n;
   logic [3:0] iSwitch;
   logic       iBtn;
   logic [3:0] oLED;
   logic [1:0] oMode;

   int checks   = 0;
   int failures = 0;

   // model state
   logic [4:0] mDelay[$];
   logic [4:0] mWin[$];
   logic [4:0] mDeb;
   bit         mPress;
   int         mMode;
   logic [3:0] mLed;
   int         mPhase;
   int         mStep;

   switch_led_controller #(.DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iSwitch (iSwitch),
      .iBtn    (iBtn),
      .oLED    (oLED),
      .oMode   (oMode)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic int nextMode(input int m);
`ifdef SWITCH_LED_BLINK_MODE_EN
      return (m + 1) % 3;
`else
      return (m + 1) % 2;
`endif
   endfunction

   task automatic modelReset();
      mDelay = '{5'b0, 5'b0};
      mWin.delete();
      mDeb   = '0;
      mPress = 0;
      mMode  = 0;
      mLed   = 4'b0000;
      mPhase = 0;
      mStep  = 0;
   endtask

   task automatic modelEdge();
      logic [4:0] cur;
      logic [4:0] nd;
      logic [3:0] oldSw;
      bit         allDiff;
      bit         tk;
      oldSw = mDeb[3:0];
      if (mPress) begin
         mMode  = nextMode(mMode);
         mPhase = 0;
         mStep  = 0;
         case (mMode)
            0:       mLed = oldSw;
            1:       mLed = 4'b0001;
            default: mLed = 4'b1111;
         endcase
      end else begin
         tk = ((mPhase % TICK) == TICK - 1);
         mPhase++;
         if (mMode == 0) mLed = oldSw;
         else if (tk) begin
            mStep++;
            if (mMode == 1) mLed = 4'(1 << (mStep % 4));
            else            mLed = (mStep % 2 != 0) ? 4'h0 : 4'hF;
         end
      end
      // two-cycle synchronizer delay, then a D-sample agreement window
      cur = mDelay.pop_front();
      mDelay.push_back({iBtn, iSwitch});
      mWin.push_back(cur);
      if (mWin.size() > DEB) void'(mWin.pop_front());
      nd = mDeb;
      if (mWin.size() == DEB) begin
         for (int b = 0; b < 5; b++) begin
            allDiff = 1;
            foreach (mWin[i]) if (mWin[i][b] == mDeb[b]) allDiff = 0;
            if (allDiff) nd[b] = cur[b];
         end
      end
      mPress = nd[4] & ~mDeb[4];
      mDeb   = nd;
   endtask

   task automatic cycle();
      @(posedge iClk);
      if (iRst_n) modelEdge();
      @(negedge iClk);
      chk("led", oLED, mLed);
      chk("mode", {2'b00, oMode}, 4'(mMode));
   endtask

   task automatic pressBtn(input int hold);
      iBtn = 1'b1;
      repeat (hold) cycle();
      iBtn = 1'b0;
      repeat (hold) cycle();
   endtask

   initial begin
      iRst_n  = 1'b0;
      iSwitch = 4'b0000;
      iBtn    = 1'b0;
      modelReset();
      #12;
      chk("reset_led", oLED, 4'b0000);
      chk("reset_mode", {2'b00, oMode}, 4'b0000);
      repeat (2) cycle();
      iRst_n = 1'b1;
      repeat (3) cycle();

      // switch-to-LED latency in PASS: 2 + DEB + 1 = 7
      iSwitch = 4'b1010;
      for (int n = 1; n <= 10; n++) begin
         cycle();
         if (n == 6) chk("pass_lat6", oLED, 4'b0000);
         if (n == 7) chk("pass_lat7", oLED, 4'b1010);
      end

      // 3-cycle glitch on bit 0 must be ignored
      iSwitch = 4'b1011;
      repeat (3) cycle();
      iSwitch = 4'b1010;
      repeat (8) cycle();
      chk("glitch", oLED, 4'b1010);

      // held button -> exactly one advance
      iBtn = 1'b1;
      repeat (50) cycle();
      chk("one_press", {2'b00, oMode}, 4'd1);
      iBtn = 1'b0;
      repeat (10) cycle();

      pressBtn(8);
`ifdef SWITCH_LED_BLINK_MODE_EN
      chk("second_press", {2'b00, oMode}, 4'd2);
`else
      chk("second_press", {2'b00, oMode}, 4'd0);
`endif
      repeat (12) cycle();
      pressBtn(8);

      // randomized switches and button, random hold lengths (glitches and real changes)
      for (int s = 0; s < 200; s++) begin
         iSwitch = 4'($urandom);
         iBtn    = ($urandom_range(0, 3) == 0);
         repeat ($urandom_range(1, 14)) cycle();
      end

      // get into CHASE, then drop reset mid-cycle
      iBtn = 1'b0;
      repeat (10) cycle();
      for (int k = 0; k < 6; k++) begin
         if (mMode == 1) break;
         pressBtn(8);
      end
      chk("in_chase", {2'b00, oMode}, 4'd1);
      repeat (11) cycle();
      #2;
      iRst_n = 1'b0;
      #1;
      chk("async_led", oLED, 4'b0000);
      chk("async_mode", {2'b00, oMode}, 4'd0);
      modelReset();
      iBtn = 1'b1;
      repeat (3) cycle();
      iRst_n = 1'b1;
      // button held across reset release: one pulse only after debounce
      repeat (3) cycle();
      chk("no_early_press", {2'b00, oMode}, 4'd0);
      repeat (40) cycle();
      chk("post_reset_press", {2'b00, oMode}, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/switch_led_controller.md
SWITCH_LED_CONTROLLER -- requirements
Module: switch_led_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive cycles an input must differ from its debounced value before the change is accepted (minimum 1).
REQ-002 SHALL have parameter TICK_CYCLES, default 25000000: period of the pattern tick in clock cycles (minimum 2).
REQ-003 SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port iRst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port iSwitch, input, 4 bits: raw slide switches, asynchronous to iClk.
REQ-006 SHALL have port iBtn, input, 1 bit: raw mode-advance pushbutton, asynchronous to iClk.
REQ-007 SHALL have port oLED, output, 4 bits: registered LED drive.
REQ-008 SHALL have port oMode, output, 2 bits: current mode (0=PASS, 1=CHASE, 2=BLINK).

Function
REQ-009 SHALL pass each of iSwitch[3:0] and iBtn through its own two-flop synchronizer.
REQ-010 SHALL debounce each synchronized bit independently with a per-bit counter that clears whenever the synchronized value equals the debounced value.
REQ-011 SHALL update a debounced bit on the edge at which its synchronized value has differed for DEBOUNCE_CYCLES consecutive cycles; any shorter glitch SHALL leave it unchanged.
REQ-012 SHALL generate a one-cycle press pulse on a debounced iBtn 0->1 transition only; a held button SHALL produce exactly one pulse.
REQ-013 SHALL implement a mode FSM with states PASS, CHASE, BLINK; each press pulse advances PASS->CHASE->BLINK->PASS.
REQ-014 SHALL run a tick counter 0..TICK_CYCLES-1, asserting an internal tick for one cycle at count TICK_CYCLES-1 and then wrapping to 0.
REQ-015 SHALL clear the tick counter to 0 on the cycle a mode change takes effect; if a tick and a press pulse coincide, the mode change SHALL win and the tick SHALL be discarded.
REQ-016 In PASS, oLED SHALL equal the debounced switches, delayed one cycle (registered).
REQ-017 On entry to CHASE, oLED SHALL be 4'b0001; each tick SHALL rotate left, 4'b1000 wrapping to 4'b0001.
REQ-018 On entry to BLINK, oLED SHALL be 4'b1111; each tick SHALL invert all four bits.
REQ-019 oMode SHALL change on the same edge as the FSM state; oLED SHALL show the entry pattern on that same edge.
REQ-020 Total latency from a stable iSwitch change to oLED in PASS SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-021 While iRst_n=0, SHALL asynchronously force oLED=4'b0000, oMode=0 (PASS), all synchronizer and debounced bits to 0, and all counters to 0.
REQ-022 A reset asserted mid-debounce or mid-pattern SHALL discard all progress; after release, behaviour SHALL be identical to power-up.
REQ-023 SHALL produce no press pulse on the first cycles after reset release, even if iBtn is held high; a pulse follows only after debounce completes (a 0->1 transition of the debounced value).

Configuration
REQ-024 With macro SWITCH_LED_BLINK_MODE_EN defined, the BLINK state and REQ-018 SHALL be compiled in.
REQ-025 Without SWITCH_LED_BLINK_MODE_EN, BLINK SHALL be absent; press pulses cycle PASS->CHASE->PASS, and oMode SHALL never equal 2.

Verification (DEBOUNCE_CYCLES=4, TICK_CYCLES=8)
REQ-026 Reset then iSwitch=4'b1010 held -> oLED=4'b0000 until cycle 7 after the change, then 4'b1010; oMode=0.
REQ-027 iSwitch[0] pulsed high for 3 cycles -> oLED[0] stays 0; debounced value unchanged.
REQ-028 iBtn held high 50 cycles -> exactly one advance: oMode 0->1, oLED=4'b0001, then 4'b0010 after 8 cycles and 4'b0001 again after 32 cycles.
REQ-029 Second press with SWITCH_LED_BLINK_MODE_EN -> oMode=2, oLED=4'b1111, then 4'b0000 after 8 cycles; third press -> oMode=0, oLED follows switches.
REQ-030 Press pulse timed to coincide with a tick in CHASE -> no rotation, mode changes, tick counter restarts at 0.
REQ-031 iRst_n dropped mid-CHASE -> oLED=4'b0000 and oMode=0 immediately, without waiting for a clock edge.
